// File: rtl/mux_arb_pkg.sv
// Shared constants for the arbitrated 2-input mux front end.
// Default data width, burst limit and mux select encoding.
package mux_arb_pkg;

    localparam int   N_DEF     = 2;
    localparam int   BURST_DEF = 2;

    localparam logic SEL_IN0   = 1'b0;
    localparam logic SEL_IN1   = 1'b1;

endpackage

// File: rtl/mux_2in_arbiter_mux.sv
// Plain 2-input N-bit multiplexer (the shared datapath lane).
// Ports: z = s ? x1 : x0; s uses the SEL_IN0/SEL_IN1 encoding.
module MUX_2INnbit
    import mux_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    output logic [N-1:0] z,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic         s
);

    assign z = (s == SEL_IN1) ? x1 : x0;

endmodule

// File: rtl/mux_2in_arbiter.sv
// Burst-limited round-robin arbiter sharing one mux between two
// valid/ready requesters, with a registered single-entry output.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   inX_valid/data/ready  : requester X handshake (X = 0, 1)
//   out_valid/data/src    : registered word and its source index
//   out_ready             : consumer takes the word
module mux_2in_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    input  logic [N-1:0] in0_data,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [N-1:0] in1_data,
    output logic         in1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready
);

    localparam int            CW     = $clog2(BURST + 1);
    localparam logic [CW-1:0] C_BMAX = CW'(BURST);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          r_last_sel;
    logic [CW-1:0] r_burst_cnt;
    logic          r_sel;
    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic          r_out_src;

    logic          w_own_v;
    logic          w_oth_v;
    logic          w_gnt_any;
    logic          w_sel;
    logic          w_load;
    logic          w_accept;
    logic [N-1:0]  w_mux;

    // Owner keeps the lane until its burst is used up or it goes idle.
    always_comb begin
        w_own_v   = r_last_sel ? in1_valid : in0_valid;
        w_oth_v   = r_last_sel ? in0_valid : in1_valid;
        w_gnt_any = 1'b1;
        w_sel     = r_last_sel;
        if (w_own_v && (r_burst_cnt < C_BMAX)) begin
            w_sel = r_last_sel;
        end else if (w_oth_v) begin
            w_sel = ~r_last_sel;
        end else if (w_own_v) begin
            w_sel = r_last_sel;
        end else begin
            w_gnt_any = 1'b0;
            w_sel     = r_sel;
        end
    end

    // The output stage refills in the same cycle it drains.
    assign w_load   = !r_out_valid || out_ready;
    assign w_accept = w_load && w_gnt_any;

    // Readies are forced low while reset is held.
    assign in0_ready = rst_n && w_accept && (w_sel == SEL_IN0);
    assign in1_ready = rst_n && w_accept && (w_sel == SEL_IN1);

    MUX_2INnbit #(
        .N (N)
    ) u_mux (
        .z  (w_mux),
        .x0 (in0_data),
        .x1 (in1_data),
        .s  (w_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= SEL_IN0;
        end else if (w_gnt_any) begin
            r_sel <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sel  <= SEL_IN1;
            r_burst_cnt <= C_BMAX;
        end else if (w_accept) begin
            if (w_sel == r_last_sel) begin
                if (r_burst_cnt != C_BMAX) begin
                    r_burst_cnt <= r_burst_cnt + C_ONE;
                end
            end else begin
                r_last_sel  <= w_sel;
                r_burst_cnt <= C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= SEL_IN0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_sel;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_2in_arbiter.sv
// Self-checking bench for mux_2in_arbiter: vector table, hand-written
// reset sequences and randomized traffic against a history-based model.
module tb_mux_2in_arbiter;

    localparam int N     = 2;
    localparam int BURST = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid;
    logic [N-1:0] in0_data;
    logic         in0_ready;
    logic         in1_valid;
    logic [N-1:0] in1_data;
    logic         in1_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_2in_arbiter #(
        .N     (N),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic         v0;
        logic [N-1:0] d0;
        logic         v1;
        logic [N-1:0] d1;
        logic         ordy;
        logic         er0;
        logic         er1;
        logic         eov;
        logic [N-1:0] eod;
        logic         esrc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(
        input logic v0, input logic [N-1:0] d0,
        input logic v1, input logic [N-1:0] d1,
        input logic ordy, input logic er0, input logic er1,
        input logic eov, input logic [N-1:0] eod, input logic esrc
    );
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ordy = ordy; v.er0 = er0; v.er1 = er1;
        v.eov = eov; v.eod = eod; v.esrc = esrc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the grant follows from the history of grants.
    bit hist[$];

    function automatic void mgrant(
        input logic v0, input logic v1,
        output logic any, output logic idx
    );
        bit owner;
        int run;
        logic own_v, oth_v;
        owner = (hist.size() == 0) ? 1'b1 : hist[hist.size() - 1];
        run = 0;
        if (hist.size() == 0) begin
            run = BURST;
        end else begin
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != owner) break;
                run++;
            end
        end
        if (run > BURST) run = BURST;
        own_v = owner ? v1 : v0;
        oth_v = owner ? v0 : v1;
        any = 1'b1;
        if (own_v && run < BURST) idx = owner;
        else if (oth_v) idx = ~owner;
        else if (own_v) idx = owner;
        else begin any = 1'b0; idx = 1'b0; end
    endfunction

    logic         m_ov;
    logic [N-1:0] m_od;
    logic         m_src;

    initial begin
        logic g_any, g_idx, ld, e0, e1, a0, a1;

        rst_n = 1'b0;
        in0_valid = 1'b1; in0_data = 2'b01;
        in1_valid = 1'b1; in1_data = 2'b10;
        out_ready = 1'b1;

        tbl[0]  = mk(1, 2'b01, 1, 2'b10, 1, 1, 0, 1, 2'b01, 0);
        tbl[1]  = mk(1, 2'b01, 1, 2'b10, 1, 1, 0, 1, 2'b01, 0);
        tbl[2]  = mk(1, 2'b01, 1, 2'b10, 1, 0, 1, 1, 2'b10, 1);
        tbl[3]  = mk(1, 2'b01, 1, 2'b10, 1, 0, 1, 1, 2'b10, 1);
        tbl[4]  = mk(1, 2'b01, 1, 2'b10, 1, 1, 0, 1, 2'b01, 0);
        tbl[5]  = mk(1, 2'b01, 1, 2'b10, 1, 1, 0, 1, 2'b01, 0);
        tbl[6]  = mk(0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 2'b11, 1);
        tbl[7]  = mk(0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 2'b11, 1);
        tbl[8]  = mk(0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 2'b11, 1);
        tbl[9]  = mk(0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 2'b11, 1);
        tbl[10] = mk(0, 2'b00, 1, 2'b11, 1, 0, 1, 1, 2'b11, 1);
        tbl[11] = mk(1, 2'b01, 1, 2'b11, 1, 1, 0, 1, 2'b01, 0);
        tbl[12] = mk(1, 2'b00, 1, 2'b11, 0, 0, 0, 1, 2'b01, 0);
        tbl[13] = mk(1, 2'b00, 1, 2'b11, 0, 0, 0, 1, 2'b01, 0);
        tbl[14] = mk(1, 2'b00, 1, 2'b11, 0, 0, 0, 1, 2'b01, 0);
        tbl[15] = mk(1, 2'b00, 1, 2'b11, 1, 1, 0, 1, 2'b00, 0);
        tbl[16] = mk(0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0);
        tbl[17] = mk(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);

        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            in0_valid = tbl[i].v0; in0_data = tbl[i].d0;
            in1_valid = tbl[i].v1; in1_data = tbl[i].d1;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in0_ready", i), in0_ready, tbl[i].er0);
            chk($sformatf("vec%0d_in1_ready", i), in1_ready, tbl[i].er1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].eod);
            chk($sformatf("vec%0d_out_src", i), out_src, tbl[i].esrc);
        end

        // Async reset between edges while a word is buffered.
        @(negedge clk);
        in0_valid = 1'b1; in0_data = 2'b01;
        in1_valid = 1'b1; in1_data = 2'b10;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("pre_arst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in0_ready", in0_ready, 0);
        chk("arst_in1_ready", in1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_arst_in0_ready", in0_ready, 1);
        chk("post_arst_in1_ready", in1_ready, 0);
        @(posedge clk);
        #1;
        chk("post_arst_out_data", out_data, 1);
        chk("post_arst_out_src", out_src, 0);

        // Randomized traffic against the model.
        @(negedge clk);
        rst_n = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        m_ov = 1'b0; m_od = '0; m_src = 1'b0;
        a0 = 1'b0; a1 = 1'b0;

        for (int c = 0; c < 400; c++) begin
            if (!in0_valid || a0) begin
                in0_valid = ($urandom_range(0, 3) != 0);
                in0_data = N'($urandom);
            end
            if (!in1_valid || a1) begin
                in1_valid = ($urandom_range(0, 3) != 0);
                in1_data = N'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            mgrant(in0_valid, in1_valid, g_any, g_idx);
            ld = !m_ov || out_ready;
            e0 = ld && g_any && (g_idx == 1'b0);
            e1 = ld && g_any && (g_idx == 1'b1);
            chk("rnd_in0_ready", in0_ready, e0);
            chk("rnd_in1_ready", in1_ready, e1);
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_out_data", out_data, m_od);
            chk("rnd_out_src", out_src, m_src);
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            if (ld && g_any) begin
                hist.push_back(g_idx);
                if (hist.size() > BURST + 1) void'(hist.pop_front());
                m_ov = 1'b1;
                m_od = g_idx ? in1_data : in0_data;
                m_src = g_idx;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
